sys_ctrl_tile: RTL and testbench

- Parametrised phase controller for an H x W weight-stationary systolic array.
- Sequences one tile per `start`: weight preload (H rows), activation streaming (`stream_len` vectors), pipeline drain, done pulse.
- Drives the array's weight/partial-sum select (`ctrl_out`) and the upstream valid/ready handshakes.
- Flags partial-sum rows as valid when they leave the array's skewed pipeline.
- Adds to the single-mode controller: weight reuse across tiles, variable stream length, backpressure, abort.

---
 rtl/sys_ctrl_tile_if.sv | 33 +++
 rtl/sys_ctrl_tile.sv | 146 ++++++++++++++
 tb/tb_sys_ctrl_tile.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/sys_ctrl_tile_if.sv
// Tile controller bus: start/abort control, weight and activation
// handshakes, and array-side status for the systolic phase controller.
interface sys_ctrl_tile_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic             reuse_w;
    logic [LEN_W-1:0] stream_len;
    logic             abort;
    logic             w_valid;
    logic             w_ready;
    logic             a_valid;
    logic             a_ready;
    logic             ctrl_out;
    logic             ps_valid;
    logic             busy;
    logic             done;
    logic [2:0]       state;

    modport master (
        output start, reuse_w, stream_len, abort,
        output w_valid, a_valid,
        input  w_ready, a_ready, ctrl_out,
        input  ps_valid, busy, done, state
    );

    modport slave (
        input  start, reuse_w, stream_len, abort,
        input  w_valid, a_valid,
        output w_ready, a_ready, ctrl_out,
        output ps_valid, busy, done, state
    );
endinterface

// File: rtl/sys_ctrl_tile.sv
// Phase controller for an H x W weight-stationary systolic array:
// preload, stream, drain, done, with weight reuse and abort.
module sys_ctrl_tile #(
    parameter int H     = 32,
    parameter int W     = 32,
    parameter int LEN_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    sys_ctrl_tile_if.slave bus
);
    localparam int D  = H + W - 1;
    localparam int DW = $clog2(D + 1);
    localparam int WW = (H > 1) ? $clog2(H) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             wgt_q, wgt_d;
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic [LEN_W-1:0] acnt_q, acnt_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [D-1:0]     pipe_q, pipe_d;

    logic w_fire, a_fire;
    logic w_last, a_last, d_last;
    logic hit, kill;

    // abort wins over any handshake presented in the same cycle
    assign w_fire = bus.w_valid & bus.w_ready & ~bus.abort;
    assign a_fire = bus.a_valid & bus.a_ready & ~bus.abort;
    assign w_last = w_fire & (wcnt_q == WW'(H - 1));
    assign a_last = a_fire & (acnt_q == len_q - LEN_W'(1));
    assign d_last = (dcnt_q == DW'(D - 1));
    assign hit    = bus.reuse_w & wgt_q;
    assign kill   = bus.abort & (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            wgt_q   <= 1'b0;
            wcnt_q  <= '0;
            acnt_q  <= '0;
            dcnt_q  <= '0;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wgt_q   <= wgt_d;
            wcnt_q  <= wcnt_d;
            acnt_q  <= acnt_d;
            dcnt_q  <= dcnt_d;
            pipe_q  <= pipe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (hit)
                        state_d = (bus.stream_len != '0) ? S_STREAM : S_DONE;
                    else
                        state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.abort)
                    state_d = S_IDLE;
                else if (w_last)
                    state_d = (len_q != '0) ? S_STREAM : S_DONE;
            end
            S_STREAM: begin
                if (bus.abort)
                    state_d = S_IDLE;
                else if (a_last)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (bus.abort)
                    state_d = S_IDLE;
                else if (d_last)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        len_d  = len_q;
        wgt_d  = wgt_q;
        wcnt_d = wcnt_q;
        acnt_d = acnt_q;
        dcnt_d = '0;
        pipe_d = (pipe_q << 1) | D'(a_fire);
        if (state_q == S_IDLE && bus.start) begin
            len_d = bus.stream_len;
            if (!hit)
                wgt_d = 1'b0;
        end
        if (w_fire)
            wcnt_d = w_last ? '0 : wcnt_q + 1'b1;
        if (w_last)
            wgt_d = 1'b1;
        if (a_fire)
            acnt_d = a_last ? '0 : acnt_q + 1'b1;
        if (state_q == S_DRAIN && !d_last)
            dcnt_d = dcnt_q + 1'b1;
        // resident weights survive an abort once preload has finished
        if (kill) begin
            wcnt_d = '0;
            acnt_d = '0;
            dcnt_d = '0;
            pipe_d = '0;
        end
    end

    always_comb begin
        bus.w_ready  = 1'b0;
        bus.a_ready  = 1'b0;
        bus.ctrl_out = 1'b0;
        bus.done     = 1'b0;
        bus.busy     = (state_q != S_IDLE);
        bus.state    = state_q;
        bus.ps_valid = pipe_q[D-1];
        case (state_q)
            S_LOAD: begin
                bus.w_ready  = 1'b1;
                bus.ctrl_out = 1'b1;
            end
            S_STREAM: bus.a_ready = 1'b1;
            S_DONE:   bus.done    = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_sys_ctrl_tile.sv
// Directed bench for sys_ctrl_tile with H=4, W=4 (D=7): tile timing,
// reuse, zero length, stalls, abort, ignored start and mid-tile reset.
module tb_sys_ctrl_tile;
    localparam int H     = 4;
    localparam int W     = 4;
    localparam int LEN_W = 16;
    localparam int D     = H + W - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sys_ctrl_tile_if #(.LEN_W(LEN_W)) bus ();

    sys_ctrl_tile #(
        .H(H), .W(W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    int cyc = 0;
    int n_psv, n_done, n_ctrl, n_ar, n_wf, n_af, n_drain;
    int fq[$];

    task automatic clear_counts();
        n_psv   = 0;
        n_done  = 0;
        n_ctrl  = 0;
        n_ar    = 0;
        n_wf    = 0;
        n_af    = 0;
        n_drain = 0;
        fq.delete();
    endtask

    // ps_valid must trail each accepted activation by exactly D cycles
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            if (bus.ps_valid) begin
                n_psv++;
                if (fq.size() == 0)
                    check("psv_spurious", 1, 0);
                else
                    check("psv_skew", cyc - fq.pop_front(), D);
            end
            if (bus.a_valid && bus.a_ready && !bus.abort) begin
                fq.push_back(cyc);
                n_af++;
            end
            if (bus.w_valid && bus.w_ready && !bus.abort)
                n_wf++;
            if (bus.done)     n_done++;
            if (bus.ctrl_out) n_ctrl++;
            if (bus.a_ready)  n_ar++;
            if (bus.state == 3'd3) n_drain++;
        end
    end

    logic       pat_en;
    logic [3:0] pat = 4'b1001;
    int         ph;

    task automatic tick();
        @(posedge clk);
        #1;
        if (pat_en) begin
            ph = ph + 1;
            bus.w_valid = pat[ph % 4];
            bus.a_valid = pat[ph % 4];
        end
    endtask

    function automatic logic [31:0] outs();
        return {23'd0, bus.state, bus.busy, bus.done, bus.ctrl_out,
                bus.ps_valid, bus.w_ready, bus.a_ready};
    endfunction

    task automatic tile(input string tg, input logic reuse,
                        input int len, input int first_st,
                        input int lat);
        int n;
        clear_counts();
        bus.start      = 1'b1;
        bus.reuse_w    = reuse;
        bus.stream_len = LEN_W'(len);
        tick();
        bus.start = 1'b0;
        check({tg, "_st0"}, 32'(bus.state), first_st);
        n = 1;
        while (!bus.done && n < 300) begin
            tick();
            n++;
        end
        check({tg, "_done"}, 32'(bus.done), 1);
        if (lat > 0)
            check({tg, "_lat"}, n, lat);
        tick();
        check({tg, "_idle"}, 32'(bus.state), 0);
    endtask

    initial begin
        int n;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.reuse_w    = 1'b0;
        bus.stream_len = '0;
        bus.abort      = 1'b0;
        bus.w_valid    = 1'b1;
        bus.a_valid    = 1'b1;
        pat_en         = 1'b0;
        ph             = 0;
        clear_counts();
        repeat (2) tick();
        check("rst_outs", outs(), 0);
        rst = 1'b0;
        tick();

        // full tile: 1 start + 4 load + 3 stream + 7 drain to done
        tile("t1", 1'b0, 3, 1, 1 + H + 3 + D);
        check("t1_ctrl", n_ctrl, 4);
        check("t1_ar", n_ar, 3);
        check("t1_psv", n_psv, 3);
        check("t1_drain", n_drain, 7);
        check("t1_ndone", n_done, 1);

        tile("t2", 1'b1, 3, 2, 1 + 3 + D);
        check("t2_ctrl", n_ctrl, 0);
        check("t2_psv", n_psv, 3);
        check("t2_ndone", n_done, 1);

        tile("t3", 1'b0, 0, 1, 1 + H);
        check("t3_wf", n_wf, 4);
        check("t3_psv", n_psv, 0);
        check("t3_ndone", n_done, 1);

        pat_en = 1'b1;
        ph     = 0;
        tile("t4", 1'b0, 5, 1, 0);
        pat_en      = 1'b0;
        bus.w_valid = 1'b1;
        bus.a_valid = 1'b1;
        check("t4_wf", n_wf, 4);
        check("t4_af", n_af, 5);
        check("t4_psv", n_psv, 5);

        // abort in the second preload cycle drops resident weights
        bus.start      = 1'b1;
        bus.reuse_w    = 1'b0;
        bus.stream_len = LEN_W'(3);
        tick();
        bus.start = 1'b0;
        tick();
        check("ab1_st", 32'(bus.state), 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("ab1_outs", outs(), 0);
        tile("t5", 1'b1, 2, 1, 1 + H + 2 + D);
        check("t5_wf", n_wf, 4);
        check("t5_psv", n_psv, 2);

        bus.start      = 1'b1;
        bus.reuse_w    = 1'b1;
        bus.stream_len = LEN_W'(5);
        tick();
        bus.start = 1'b0;
        check("ab2_st", 32'(bus.state), 2);
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("ab2_outs", outs(), 0);
        clear_counts();
        repeat (12) tick();
        check("ab2_psv", n_psv, 0);
        check("ab2_ndone", n_done, 0);
        tile("t6", 1'b1, 1, 2, 1 + 1 + D);

        // start while streaming and while in DONE must be ignored
        clear_counts();
        bus.start      = 1'b1;
        bus.reuse_w    = 1'b1;
        bus.stream_len = LEN_W'(3);
        tick();
        bus.stream_len = LEN_W'(9);
        bus.reuse_w    = 1'b0;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 100) begin
            tick();
            n++;
        end
        check("ig_done", 32'(bus.done), 1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("ig_st1", 32'(bus.state), 0);
        tick();
        check("ig_st2", 32'(bus.state), 0);
        check("ig_psv", n_psv, 3);
        check("ig_ctrl", n_ctrl, 0);

        bus.start      = 1'b1;
        bus.reuse_w    = 1'b1;
        bus.stream_len = LEN_W'(2);
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        check("dr_st", 32'(bus.state), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("dr_rst_outs", outs(), 0);
        clear_counts();
        repeat (10) tick();
        check("dr_psv", n_psv, 0);
        tile("t7", 1'b1, 1, 1, 1 + H + 1 + D);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
